// File: rtl/imm_field_decode.sv
// Decode-stage front end: splits fetched RISC-V words into register fields and a
// packed raw immediate, buffered in a 2-entry skid FIFO so in_ready is registered.
module imm_field_decode (
  input  logic        clk,
  input  logic        rst,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [31:0] in_instr,
  input  logic [31:0] in_pc,
  input  logic        flush,
  output logic        out_valid,
  input  logic        out_ready,
  output logic [31:0] out_pc,
  output logic [6:0]  out_opcode,
  output logic [4:0]  out_rd,
  output logic [4:0]  out_rs1,
  output logic [4:0]  out_rs2,
  output logic [2:0]  out_funct3,
  output logic [6:0]  out_funct7,
  output logic [19:0] out_imm_in,
  output logic [1:0]  out_imm_ext_en,
  output logic [1:0]  out_imm_sh,
  output logic        out_illegal
);

  localparam logic [6:0] OP_LOAD   = 7'b0000011;
  localparam logic [6:0] OP_FENCE  = 7'b0001111;
  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_AUIPC  = 7'b0010111;
  localparam logic [6:0] OP_STORE  = 7'b0100011;
  localparam logic [6:0] OP_OP     = 7'b0110011;
  localparam logic [6:0] OP_LUI    = 7'b0110111;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [6:0] OP_JALR   = 7'b1100111;
  localparam logic [6:0] OP_JAL    = 7'b1101111;
  localparam logic [6:0] OP_SYSTEM = 7'b1110011;

  localparam logic [1:0] EXT_S12 = 2'b00;
  localparam logic [1:0] EXT_S20 = 2'b01;
  localparam logic [1:0] EXT_U12 = 2'b10;
  localparam logic [1:0] EXT_U20 = 2'b11;

  localparam logic [1:0] SH_NONE = 2'b00;
  localparam logic [1:0] SH_1    = 2'b01;
  localparam logic [1:0] SH_12   = 2'b10;

  typedef enum logic [1:0] {
    EMPTY = 2'b00,
    ONE   = 2'b01,
    TWO   = 2'b10
  } state_t;

  typedef struct packed {
    logic [31:0] pc;
    logic [6:0]  opcode;
    logic [4:0]  rd;
    logic [4:0]  rs1;
    logic [4:0]  rs2;
    logic [2:0]  funct3;
    logic [6:0]  funct7;
    logic [19:0] imm_in;
    logic [1:0]  imm_ext_en;
    logic [1:0]  imm_sh;
    logic        illegal;
  } entry_t;

  function automatic entry_t decode_instr(input logic [31:0] instr, input logic [31:0] pc);
    entry_t e;
    e        = '0;
    e.pc     = pc;
    e.opcode = instr[6:0];
    e.rd     = instr[11:7];
    e.rs1    = instr[19:15];
    e.rs2    = instr[24:20];
    e.funct3 = instr[14:12];
    e.funct7 = instr[31:25];
    case (instr[6:0])
      OP_LOAD, OP_JALR: begin
        e.imm_in = {8'b0, instr[31:20]};
      end
      OP_IMM: begin
        // funct3 001/101 are the shift-immediate forms; shamt is unsigned
        if (instr[13:12] == 2'b01) begin
          e.imm_in     = {15'b0, instr[24:20]};
          e.imm_ext_en = EXT_U12;
        end else begin
          e.imm_in = {8'b0, instr[31:20]};
        end
      end
      OP_STORE: begin
        e.imm_in = {8'b0, instr[31:25], instr[11:7]};
      end
      OP_BRANCH: begin
        e.imm_in = {8'b0, instr[31], instr[7], instr[30:25], instr[11:8]};
        e.imm_sh = SH_1;
      end
      OP_JAL: begin
        e.imm_in     = {instr[31], instr[19:12], instr[20], instr[30:21]};
        e.imm_ext_en = EXT_S20;
        e.imm_sh     = SH_1;
      end
      OP_LUI, OP_AUIPC: begin
        e.imm_in     = instr[31:12];
        e.imm_ext_en = EXT_U20;
        e.imm_sh     = SH_12;
      end
      OP_SYSTEM: begin
        if (instr[14]) begin
          e.imm_in     = {15'b0, instr[19:15]};
          e.imm_ext_en = EXT_U12;
        end
      end
      OP_OP, OP_FENCE: begin
        e.imm_in = '0;
      end
      default: begin
        e.illegal = 1'b1;
      end
    endcase
    if (instr[1:0] != 2'b11) begin
      e.illegal    = 1'b1;
      e.imm_in     = '0;
      e.imm_ext_en = EXT_S12;
      e.imm_sh     = SH_NONE;
    end
    return e;
  endfunction

  entry_t dec_p0;
  entry_t head_p1;
  entry_t skid_p1;
  state_t state_q;
  state_t state_d;
  logic   in_ready_q;
  logic   push;
  logic   pop;
  logic   load_head_dec;
  logic   load_head_skid;
  logic   load_skid;

  // Stage 0: combinational decode of the incoming word
  assign dec_p0 = decode_instr(in_instr, in_pc);
  assign push   = in_valid & in_ready_q;
  assign pop    = (state_q != EMPTY) & out_ready;

  always_comb begin
    state_d        = state_q;
    load_head_dec  = 1'b0;
    load_head_skid = 1'b0;
    load_skid      = 1'b0;
    case (state_q)
      EMPTY: begin
        if (push) begin
          state_d       = ONE;
          load_head_dec = 1'b1;
        end
      end
      ONE: begin
        if (push && pop) begin
          load_head_dec = 1'b1;
        end else if (push) begin
          state_d   = TWO;
          load_skid = 1'b1;
        end else if (pop) begin
          state_d = EMPTY;
        end
      end
      TWO: begin
        if (pop) begin
          state_d        = ONE;
          load_head_skid = 1'b1;
        end
      end
      default: begin
        state_d = EMPTY;
      end
    endcase
    // Flush drops everything, including a push landing on the same edge
    if (flush) begin
      state_d        = EMPTY;
      load_head_dec  = 1'b0;
      load_head_skid = 1'b0;
      load_skid      = 1'b0;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q    <= EMPTY;
      in_ready_q <= 1'b1;
    end else begin
      state_q    <= state_d;
      in_ready_q <= (state_d != TWO);
    end
  end

  // Stage 1: head/skid entry registers feeding the outputs directly
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      head_p1 <= '0;
      skid_p1 <= '0;
    end else begin
      if (load_head_dec) begin
        head_p1 <= dec_p0;
      end else if (load_head_skid) begin
        head_p1 <= skid_p1;
      end
      if (load_skid) begin
        skid_p1 <= dec_p0;
      end
    end
  end

  assign in_ready       = in_ready_q;
  assign out_valid      = (state_q != EMPTY);
  assign out_pc         = head_p1.pc;
  assign out_opcode     = head_p1.opcode;
  assign out_rd         = head_p1.rd;
  assign out_rs1        = head_p1.rs1;
  assign out_rs2        = head_p1.rs2;
  assign out_funct3     = head_p1.funct3;
  assign out_funct7     = head_p1.funct7;
  assign out_imm_in     = head_p1.imm_in;
  assign out_imm_ext_en = head_p1.imm_ext_en;
  assign out_imm_sh     = head_p1.imm_sh;
  assign out_illegal    = head_p1.illegal;

endmodule

// File: tb/tb_imm_field_decode.sv
// Bench for imm_field_decode: table of encodings with expected immediates,
// a scoreboard on the output handshake, and hand-written buffer sequences.
module tb_imm_field_decode;

  logic        clk = 1'b0;
  logic        rst;
  logic        in_valid;
  logic        in_ready;
  logic [31:0] in_instr;
  logic [31:0] in_pc;
  logic        flush;
  logic        out_valid;
  logic        out_ready;
  logic [31:0] out_pc;
  logic [6:0]  out_opcode;
  logic [4:0]  out_rd;
  logic [4:0]  out_rs1;
  logic [4:0]  out_rs2;
  logic [2:0]  out_funct3;
  logic [6:0]  out_funct7;
  logic [19:0] out_imm_in;
  logic [1:0]  out_imm_ext_en;
  logic [1:0]  out_imm_sh;
  logic        out_illegal;

  imm_field_decode dut (
    .clk(clk), .rst(rst),
    .in_valid(in_valid), .in_ready(in_ready), .in_instr(in_instr), .in_pc(in_pc),
    .flush(flush),
    .out_valid(out_valid), .out_ready(out_ready), .out_pc(out_pc),
    .out_opcode(out_opcode), .out_rd(out_rd), .out_rs1(out_rs1), .out_rs2(out_rs2),
    .out_funct3(out_funct3), .out_funct7(out_funct7), .out_imm_in(out_imm_in),
    .out_imm_ext_en(out_imm_ext_en), .out_imm_sh(out_imm_sh), .out_illegal(out_illegal)
  );

  always #5 clk = ~clk;

  typedef struct {
    logic [31:0] instr;
    logic [19:0] imm;
    logic [1:0]  ext;
    logic [1:0]  sh;
    logic        ill;
  } vec_t;

  localparam int NV = 20;
  vec_t        tbl [NV];
  vec_t        cur_vec;
  logic [88:0] sb [$];
  logic [88:0] act;
  logic [88:0] held;
  int          n_chk = 0;
  int          n_fail = 0;
  logic        rnd_mode = 1'b0;

  assign act = {out_pc, out_opcode, out_rd, out_rs1, out_rs2, out_funct3, out_funct7,
                out_imm_in, out_imm_ext_en, out_imm_sh, out_illegal};

  function automatic logic [88:0] model(input vec_t v, input logic [31:0] pc);
    logic [31:0] w;
    w = v.instr;
    return {pc, w[6:0], w[11:7], w[19:15], w[24:20], w[14:12], w[31:25],
            v.imm, v.ext, v.sh, v.ill};
  endfunction

  task automatic check(input string name, input logic [88:0] got, input logic [88:0] exp);
    n_chk++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h", name, got, exp);
    end
  endtask

  task automatic fail_now(input string name);
    n_chk++;
    n_fail++;
    $display("FAIL %s: bound expired", name);
  endtask

  // Scoreboard: compare on pop, enqueue on push; flush clears after any pop
  always @(negedge clk) begin
    if (!rst) begin
      if (out_valid && out_ready) begin
        if (sb.size() == 0) begin
          check("unexpected_out", act, '0);
          if (act == '0) begin
            n_fail++;
            $display("FAIL unexpected_out: got entry expected none");
          end
        end else begin
          check("scoreboard", act, sb.pop_front());
        end
      end
      if (flush) sb.delete();
      else if (in_valid && in_ready) sb.push_back(model(cur_vec, in_pc));
    end
  end

  always @(posedge clk) begin
    if (rnd_mode) begin
      #1 out_ready = 1'($urandom_range(0, 1));
    end
  end

  task automatic send(input vec_t v, input logic [31:0] pc, output int cyc);
    logic got;
    cur_vec  = v;
    in_instr = v.instr;
    in_pc    = pc;
    in_valid = 1'b1;
    cyc      = 0;
    do begin
      @(negedge clk);
      got = in_ready;
      @(posedge clk);
      #1;
      cyc++;
    end while (!got && cyc < 200);
    in_valid = 1'b0;
    if (!got) fail_now("send_timeout");
  endtask

  task automatic drain();
    int n;
    n = 0;
    out_ready = 1'b1;
    do begin
      @(negedge clk);
      n++;
    end while ((sb.size() != 0 || out_valid) && n < 200);
    if (n >= 200) fail_now("drain_timeout");
    @(posedge clk);
    #1;
  endtask

  initial begin
    int c;
    int total;
    tbl[0]  = '{32'hFFF00093, 20'h00FFF, 2'b00, 2'b00, 1'b0}; // ADDI x1,x0,-1
    tbl[1]  = '{32'h123452B7, 20'h12345, 2'b11, 2'b10, 1'b0}; // LUI
    tbl[2]  = '{32'h4071D113, 20'h00007, 2'b10, 2'b00, 1'b0}; // SRAI
    tbl[3]  = '{32'hFE000EE3, 20'h00FFE, 2'b00, 2'b01, 1'b0}; // BEQ -4
    tbl[4]  = '{32'h001000EF, 20'h00400, 2'b01, 2'b01, 1'b0}; // JAL +2048
    tbl[5]  = '{32'h00000000, 20'h00000, 2'b00, 2'b00, 1'b1}; // all-zero word
    tbl[6]  = '{32'h00512423, 20'h00008, 2'b00, 2'b00, 1'b0}; // SW +8
    tbl[7]  = '{32'hFE102FA3, 20'h00FFF, 2'b00, 2'b00, 1'b0}; // SW -1
    tbl[8]  = '{32'h3002D073, 20'h00005, 2'b10, 2'b00, 1'b0}; // CSRRWI
    tbl[9]  = '{32'h00000073, 20'h00000, 2'b00, 2'b00, 1'b0}; // ECALL
    tbl[10] = '{32'h002081B3, 20'h00000, 2'b00, 2'b00, 1'b0}; // ADD
    tbl[11] = '{32'h0FF0000F, 20'h00000, 2'b00, 2'b00, 1'b0}; // FENCE
    tbl[12] = '{32'hFFFFF517, 20'hFFFFF, 2'b11, 2'b10, 1'b0}; // AUIPC
    tbl[13] = '{32'hFF808067, 20'h00FF8, 2'b00, 2'b00, 1'b0}; // JALR -8
    tbl[14] = '{32'h0042A203, 20'h00004, 2'b00, 2'b00, 1'b0}; // LW +4
    tbl[15] = '{32'h01F09093, 20'h0001F, 2'b10, 2'b00, 1'b0}; // SLLI 31
    tbl[16] = '{32'h00004501, 20'h00000, 2'b00, 2'b00, 1'b1}; // bits[1:0]=01
    tbl[17] = '{32'h0000007F, 20'h00000, 2'b00, 2'b00, 1'b1}; // unknown opcode
    tbl[18] = '{32'hFFFFF06F, 20'hFFFFF, 2'b01, 2'b01, 1'b0}; // JAL -2
    tbl[19] = '{32'h002090E3, 20'h00400, 2'b00, 2'b01, 1'b0}; // BNE +2048

    rst = 1'b1; in_valid = 1'b0; in_instr = '0; in_pc = '0; flush = 1'b0; out_ready = 1'b0;
    cur_vec = tbl[0];
    #1;
    check("reset_async", {in_ready, out_valid, act}, {1'b1, 1'b0, 89'd0});
    @(posedge clk); @(posedge clk); #1;
    check("reset_held", {in_ready, out_valid, act}, {1'b1, 1'b0, 89'd0});
    rst = 1'b0;

    out_ready = 1'b1;
    send(tbl[0], 32'h0000_0100, c);
    check("first_push_cycles", 89'(c), 89'd1);
    check("latency_valid", {88'd0, out_valid}, 89'd1);
    check("addi_direct", act, model(tbl[0], 32'h0000_0100));
    drain();

    total = 0;
    for (int i = 0; i < NV; i++) begin
      send(tbl[i], 32'h0000_1000 + 32'(i * 4), c);
      total += c;
    end
    check("throughput_cycles", 89'(total), 89'(NV));
    drain();

    out_ready = 1'b0;
    send(tbl[1], 32'h0000_2000, c);
    send(tbl[2], 32'h0000_2004, c);
    check("two_ready_valid", {87'd0, in_ready, out_valid}, {87'd0, 1'b0, 1'b1});
    check("two_head", act, model(tbl[1], 32'h0000_2000));
    held = act;
    repeat (3) @(posedge clk);
    #1;
    check("stall_hold", act, held);
    drain();

    out_ready = 1'b0;
    send(tbl[3], 32'h0000_3000, c);
    send(tbl[4], 32'h0000_3004, c);
    cur_vec = tbl[6]; in_instr = tbl[6].instr; in_pc = 32'h0000_3008;
    in_valid = 1'b1; flush = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_two", {87'd0, in_ready, out_valid}, {87'd0, 1'b1, 1'b0});
    out_ready = 1'b1;
    repeat (4) @(posedge clk);
    #1;
    check("flush_stays_empty", {56'd0, out_valid, 32'(sb.size())}, 89'd0);

    out_ready = 1'b0;
    send(tbl[7], 32'h0000_3100, c);
    cur_vec = tbl[8]; in_instr = tbl[8].instr; in_pc = 32'h0000_3104;
    in_valid = 1'b1; flush = 1'b1; out_ready = 1'b1;
    @(posedge clk); #1;
    flush = 1'b0; in_valid = 1'b0;
    check("flush_with_pop", {87'd0, in_ready, out_valid}, {87'd0, 1'b1, 1'b0});
    drain();

    rnd_mode = 1'b1;
    for (int i = 0; i < NV; i++) send(tbl[i], 32'h0000_4000 + 32'(i * 4), c);
    rnd_mode = 1'b0;
    @(posedge clk); #2;
    drain();
    check("random_sb_empty", 89'(sb.size()), 89'd0);

    out_ready = 1'b0;
    send(tbl[12], 32'h0000_5000, c);
    send(tbl[13], 32'h0000_5004, c);
    #2;
    rst = 1'b1;
    sb.delete();
    #1;
    check("reset_midstream", {in_ready, out_valid, act}, {1'b1, 1'b0, 89'd0});
    @(posedge clk); #1;
    rst = 1'b0;
    out_ready = 1'b1;
    send(tbl[5], 32'h0000_6000, c);
    check("push_after_reset", 89'(c), 89'd1);
    check("zero_word_illegal", act, model(tbl[5], 32'h0000_6000));
    drain();

    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
